ex_alu_stage: RTL

- Execute stage of the 16-bit pipelined core, directly downstream of decode.
- Consumes the fetched instruction word, the decoder's sign bit, and the two already-selected 16-bit operands.
- Computes the ALU result and flags, then holds them in a one-deep registered EX/MEM slot with a valid/ready handshake, stall and flush.

---
 rtl/ex_alu_stage_pkg.sv | 32 +++
 rtl/ex_alu_stage_if.sv | 27 ++
 rtl/ex_alu_stage_alu_shifter.sv | 17 +
 rtl/ex_alu_stage.sv | 91 +++++++++
 4 files changed

// File: rtl/ex_alu_stage_pkg.sv
// ex_alu_stage_pkg: opcodes, func codes, shift modes and helpers shared by the EX stage.
package ex_alu_stage_pkg;
    localparam int ALU_DW = 16;
    localparam logic [4:0] OP_ADDI    = 5'b01000;
    localparam logic [4:0] OP_SUBI    = 5'b01001;
    localparam logic [4:0] OP_XORI    = 5'b01010;
    localparam logic [4:0] OP_ANDNI   = 5'b01011;
    localparam logic [4:0] OP_ST      = 5'b10000;
    localparam logic [4:0] OP_LD      = 5'b10001;
    localparam logic [4:0] OP_SLBI    = 5'b10010;
    localparam logic [4:0] OP_STU     = 5'b10011;
    localparam logic [4:0] OP_ROLI    = 5'b10100;
    localparam logic [4:0] OP_SLLI    = 5'b10101;
    localparam logic [4:0] OP_RORI    = 5'b10110;
    localparam logic [4:0] OP_SRLI    = 5'b10111;
    localparam logic [4:0] OP_LBI     = 5'b11000;
    localparam logic [4:0] OP_BTR     = 5'b11001;
    localparam logic [4:0] OP_SHIFT_R = 5'b11010;
    localparam logic [4:0] OP_RRR     = 5'b11011;
    localparam logic [4:0] OP_SEQ     = 5'b11100;
    localparam logic [4:0] OP_SLT     = 5'b11101;
    localparam logic [4:0] OP_SLE     = 5'b11110;
    localparam logic [4:0] OP_SCO     = 5'b11111;
    localparam logic [1:0] FN_ADD  = 2'b00;
    localparam logic [1:0] FN_SUB  = 2'b01;
    localparam logic [1:0] FN_XOR  = 2'b10;
    localparam logic [1:0] FN_ANDN = 2'b11;
    typedef enum logic [1:0] {SH_ROL, SH_SLL, SH_ROR, SH_SRL} sh_mode_t;
    function automatic logic [ALU_DW-1:0] bit_rev(input logic [ALU_DW-1:0] v);
        for (int i = 0; i < ALU_DW; i++) bit_rev[i] = v[ALU_DW-1-i];
    endfunction
endpackage

// File: rtl/ex_alu_stage_if.sv
// ex_alu_stage_if: decode-side inputs and EX/MEM slot outputs of the execute stage.
interface ex_alu_if #(parameter int DW = 16, parameter int RW = 3);
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   instr;
    logic          sign;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [RW-1:0] rd_in;
    logic          flush;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] result;
    logic [RW-1:0] rd_out;
    logic          zero;
    logic          cout;
    logic          ovf;
    logic          err;
    modport master (
        output in_valid, instr, sign, op_a, op_b, rd_in, flush, out_ready,
        input  in_ready, out_valid, result, rd_out, zero, cout, ovf, err
    );
    modport slave (
        input  in_valid, instr, sign, op_a, op_b, rd_in, flush, out_ready,
        output in_ready, out_valid, result, rd_out, zero, cout, ovf, err
    );
endinterface

// File: rtl/ex_alu_stage_alu_shifter.sv
// alu_shifter: combinational 16-bit rotate-left/shift-left/rotate-right/shift-right-logical.
module alu_shifter
    import ex_alu_stage_pkg::*;
(
    input  logic [ALU_DW-1:0] a,
    input  logic [3:0]        shamt,
    input  sh_mode_t          mode,
    output logic [ALU_DW-1:0] y
);
    logic [3:0] nsh;
    // Complementary amount wraps to 0 for shamt 0, so rotates then OR a with itself.
    assign nsh = 4'd0 - shamt;
    assign y = mode == SH_ROL ? (a << shamt) | (a >> nsh) :
               mode == SH_SLL ? a << shamt :
               mode == SH_ROR ? (a >> shamt) | (a << nsh) :
                                a >> shamt;
endmodule

// File: rtl/ex_alu_stage.sv
// ex_alu_stage: 16-bit EX ALU feeding a one-deep EX/MEM slot; ALU_OVF_TRAP_EN enables the signed-overflow trap.
module ex_alu_stage #(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input logic   clk,
    input logic   rst,
    ex_alu_if.slave bus
);
    import ex_alu_stage_pkg::*;
    logic [4:0]    op;
    logic [1:0]    fn;
    logic [DW-1:0] a, b, add_x, add_y, sh_y, res_n;
    logic [DW:0]   sum;
    logic          is_sub, use_add, s_ovf, lt, le, known, cout_n, ovf_n, err_n, load;
    logic          unused_instr;
    sh_mode_t      sh_mode;
    assign op = bus.instr[15:11];
    assign fn = bus.instr[1:0];
    assign a = bus.op_a;
    assign b = bus.op_b;
    assign unused_instr = ^bus.instr[10:2];
    assign is_sub = op == OP_SUBI || (op == OP_RRR && fn == FN_SUB);
    assign use_add = op inside {OP_ADDI, OP_SUBI, OP_ST, OP_LD, OP_STU, OP_SCO} ||
                     (op == OP_RRR && !fn[1]);
    // Subtraction is op_b - op_a, done as op_b + ~op_a + 1 on the same adder.
    assign add_x = is_sub ? b : a;
    assign add_y = is_sub ? ~a : b;
    assign sum = {1'b0, add_x} + {1'b0, add_y} + {{DW{1'b0}}, is_sub};
    assign s_ovf = add_x[DW-1] == add_y[DW-1] && sum[DW-1] != add_x[DW-1];
    assign lt = bus.sign ? $signed(a) < $signed(b) : a < b;
    assign le = lt || a == b;
    assign sh_mode = sh_mode_t'(op == OP_SHIFT_R ? fn : op[1:0]);
    alu_shifter u_shifter (
        .a    (a),
        .shamt(b[3:0]),
        .mode (sh_mode),
        .y    (sh_y)
    );
    always_comb begin
        res_n = '0;
        known = 1'b1;
        case (op)
            OP_ADDI, OP_SUBI, OP_ST, OP_LD, OP_STU: res_n = sum[DW-1:0];
            OP_XORI:  res_n = a ^ b;
            OP_ANDNI: res_n = a & ~b;
            OP_SLBI:  res_n = (a << 8) | DW'(b[7:0]);
            OP_LBI:   res_n = b;
            OP_BTR:   res_n = bit_rev(a);
            OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI, OP_SHIFT_R: res_n = sh_y;
            OP_RRR:   res_n = fn == FN_XOR ? a ^ b : fn == FN_ANDN ? a & ~b : sum[DW-1:0];
            OP_SEQ:   res_n = DW'(a == b);
            OP_SLT:   res_n = DW'(lt);
            OP_SLE:   res_n = DW'(le);
            OP_SCO:   res_n = DW'(sum[DW]);
            default:  known = 1'b0;
        endcase
    end
    assign cout_n = use_add & sum[DW];
    assign ovf_n = use_add & (bus.sign ? s_ovf : sum[DW]);
`ifdef ALU_OVF_TRAP_EN
    logic trap_op;
    assign trap_op = op inside {OP_ADDI, OP_SUBI} || (op == OP_RRR && !fn[1]);
    assign err_n = bus.sign & s_ovf & trap_op;
`else
    assign err_n = 1'b0;
`endif
    assign bus.in_ready = !bus.out_valid | bus.out_ready;
    assign load = bus.in_valid & bus.in_ready & !bus.flush;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.rd_out    <= '0;
            bus.zero      <= 1'b0;
            bus.cout      <= 1'b0;
            bus.ovf       <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.out_valid <= !bus.flush & (load | (bus.out_valid & !bus.out_ready));
            if (load) begin
                bus.result <= err_n ? '0 : res_n;
                bus.rd_out <= err_n ? '0 : bus.rd_in;
                bus.zero   <= known & (err_n | res_n == '0);
                bus.cout   <= cout_n;
                bus.ovf    <= ovf_n;
                bus.err    <= err_n;
            end
        end
    end
endmodule
